if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the program counter and drives the word address into the combinational instruction memory (6-bit word address, 32-bit read data).
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump redirects, decode stalls and flushes, plus a post-reset bubble and a halt state.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0.
- IMEM_AW, 6, instruction-memory word-address width; imem_a = pc[IMEM_AW+1:2].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard unit: hold PC and IF/ID contents
- flush  input  1  squash the instruction currently in IF/ID
- br_taken  input  1  EX-stage branch resolved taken
- br_target  input  32  branch byte target
- jmp  input  1  ID-stage jump
- jmp_target  input  32  jump byte target
- halt  input  1  stop fetching (sticky until reset)
- imem_a  output  IMEM_AW  word address to instruction memory
- imem_rd  input  32  instruction word from instruction memory (combinational)
- pc_if  output  32  current fetch PC
- instr_id  output  32  IF/ID instruction
- pc4_id  output  32  IF/ID PC+4
- valid_id  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): pc_if=RESET_PC, instr_id=0 (NOP), pc4_id=0, valid_id=0, state=S_BOOT. Reset mid-operation aborts everything immediately, with no waiting for clk.
- imem_a = pc_if[IMEM_AW+1:2], purely combinational from the PC register. Bits above IMEM_AW+1 are ignored, so addresses alias (PC 0x100 fetches word 0).
- FSM: S_BOOT, S_RUN, S_HALT.
- S_BOOT: lasts 1 cycle after reset release. PC holds, IF/ID stays a bubble (valid_id=0). Then go to S_RUN.
- S_RUN, next-PC priority (highest first):
  - br_taken -> {br_target[31:2],2'b00}
  - jmp -> {jmp_target[31:2],2'b00}
  - stall -> hold
  - otherwise pc+4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000)
- A redirect overrides stall: the PC still updates.
- IF/ID update each S_RUN cycle:
  - flush or br_taken: instr_id=0, pc4_id=0, valid_id=0. Flush beats stall.
  - else stall: hold all IF/ID fields.
  - else jmp: load a bubble, because the fall-through word is squashed.
  - else: instr_id=imem_rd, pc4_id=pc_if+4, valid_id=1.
- Latency: a word fetched at PC in cycle N appears on instr_id in cycle N+1. A redirect in cycle N fetches the target in N+1, and the target instruction is valid in ID in N+2.
- halt=1 in S_RUN: go to S_HALT at the next edge. IF/ID takes a bubble on that edge. PC freezes at its value from the halt cycle.
- S_HALT: PC frozen, IF/ID bubble, all inputs ignored. Exit only via reset.
- Simultaneous halt and br_taken: the PC takes the branch target, then freezes there.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every cycle IF/ID loads with valid_id=1.
  - stall_cnt increments on every S_RUN cycle with stall=1 and no flush.
  - Both wrap at 2^32 and freeze in S_HALT.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, then release -> cycle 1: valid_id=0, pc_if=0. Cycle 2: pc_if=4, instr_id=RAM[0], pc4_id=4, valid_id=1.
- Sequential run over 64 words -> after word 63, pc_if=0x100 and imem_a=0 (alias). instr_id follows RAM[k], one cycle behind.
- stall=1 for 3 cycles at pc_if=0x10 -> pc_if and instr_id unchanged for 3 cycles. Next cycle pc_if=0x14.
- br_taken=1, br_target=0x23 together with stall=1 -> next pc_if=0x20 and valid_id=0. One cycle later instr_id=RAM[8].
- jmp=1, jmp_target=0x40 while flush=1 -> pc_if=0x40 and a bubble. Also check br_taken+jmp together -> br_target wins.
- halt=1 at pc_if=0x18 -> pc_if stays 0x18 and valid_id=0 forever. Assert rst_n=0 mid-cycle -> outputs reset immediately. With IF_PERF_CNT_EN, fetch_cnt equals the number of valid_id=1 loads.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
// Define IF_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counters.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               br_taken,
   input  logic [31:0]        br_target,
   input  logic               jmp,
   input  logic [31:0]        jmp_target,
   input  logic               halt,
   output logic [IMEM_AW-1:0] imem_a,
   input  logic [31:0]        imem_rd,
   output logic [31:0]        pc_if,
   output logic [31:0]        instr_id,
   output logic [31:0]        pc4_id,
   output logic               valid_id
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] pc4;
   logic [31:0] br_pc;
   logic [31:0] jmp_pc;
   logic        ld_word;
   logic        ld_bubble;
   logic        unused_tgt_lsbs;

   assign imem_a          = pc_if[IMEM_AW+1:2];
   assign pc4             = pc_if + 32'd4;
   assign br_pc           = {br_target[31:2], 2'b00};
   assign jmp_pc          = {jmp_target[31:2], 2'b00};
   assign unused_tgt_lsbs = ^{br_target[1:0], jmp_target[1:0]};

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_if;
      ld_word   = 1'b0;
      ld_bubble = 1'b0;
      case (state)
         S_BOOT: begin
            state_nxt = S_RUN;
            ld_bubble = 1'b1;
         end
         S_RUN: begin
            if (br_taken)    pc_nxt = br_pc;
            else if (jmp)    pc_nxt = jmp_pc;
            else if (!stall) pc_nxt = pc4;
            // Halting freezes the PC, except that a same-cycle branch still lands first.
            if (halt) begin
               state_nxt = S_HALT;
               ld_bubble = 1'b1;
               if (!br_taken) pc_nxt = pc_if;
            end else if (flush || br_taken) begin
               ld_bubble = 1'b1;
            end else if (!stall) begin
               if (jmp) ld_bubble = 1'b1;
               else     ld_word   = 1'b1;
            end
         end
         S_HALT: begin
            ld_bubble = 1'b1;
         end
         default: begin
            state_nxt = S_HALT;
            ld_bubble = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_BOOT;
         pc_if <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc_if <= pc_nxt;
      end
   end

   // IF -> ID pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_id <= 32'd0;
         pc4_id   <= 32'd0;
         valid_id <= 1'b0;
      end else if (ld_bubble) begin
         instr_id <= 32'd0;
         pc4_id   <= 32'd0;
         valid_id <= 1'b0;
      end else if (ld_word) begin
         instr_id <= imem_rd;
         pc4_id   <= pc4;
         valid_id <= 1'b1;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (ld_word) fetch_cnt <= fetch_cnt + 32'd1;
         if ((state == S_RUN) && stall && !flush) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
